// File: rtl/approx_add_pkg.sv
// approx_add_pkg: mode encoding and width-generic approximate-sum function
package approx_add_pkg;
   typedef enum logic [1:0] {
      MODE_EXACT = 2'd0,
      MODE_LOA   = 2'd1,
      MODE_TRUNC = 2'd2,
      MODE_ETA   = 2'd3
   } mode_t;
   localparam int MAX_W = 64;
   typedef logic [MAX_W-1:0] opnd_t;
   typedef logic [MAX_W:0]   wide_t;
   // Operands arrive zero-extended; k low bits are approximated, k=0 degenerates to exact
   function automatic wide_t approx_sum(input opnd_t a, input opnd_t b, input mode_t mode, input int k);
      opnd_t m;
      wide_t low;
      wide_t up;
      logic  cin;
      m   = (opnd_t'(1) << k) - opnd_t'(1);
      cin = (mode == MODE_LOA) && (|(a & b & (m ^ (m >> 1))));
      low = (mode == MODE_LOA) ? wide_t'((a | b) & m) : (mode == MODE_ETA) ? wide_t'((a + b) & m) : '0;
      up  = wide_t'(a >> k) + wide_t'(b >> k) + wide_t'(cin);
      return (mode == MODE_EXACT) ? wide_t'(a) + wide_t'(b) : (up << k) | low;
   endfunction
endpackage

// File: rtl/approx_add_core.sv
// approx_add_core: combinational approximate sum, exact sum and absolute error
module approx_add_core
   import approx_add_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int K     = 3
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  mode_t            i_mode,
   output logic [WIDTH:0]   o_sum,
   output logic [WIDTH:0]   o_err
);
   logic [WIDTH:0] w_exact;
   assign o_sum   = (WIDTH+1)'(approx_sum(opnd_t'(i_a), opnd_t'(i_b), i_mode, K));
   assign w_exact = {1'b0, i_a} + {1'b0, i_b};
   assign o_err   = (o_sum > w_exact) ? o_sum - w_exact : w_exact - o_sum;
endmodule

// File: rtl/approx_add_pipe.sv
// approx_add_pipe: pipelined approximate adder with valid/ready handshake
// and saturating accuracy statistics (count, EP, MAE numerator, WCE)
module approx_add_pipe
   import approx_add_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int K      = 3,
   parameter int STAGES = 2,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic [WIDTH:0]   out_err,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_count,
   output logic [CNT_W-1:0] stat_err_count,
   output logic [CNT_W-1:0] stat_err_sum,
   output logic [WIDTH:0]   stat_wce
);
   logic [WIDTH:0]    w_sum;
   logic [WIDTH:0]    w_err;
   logic [STAGES-1:0] w_ld;
   logic [STAGES-1:0] r_vld;
   logic [WIDTH:0]    r_sum [STAGES];
   logic [WIDTH:0]    r_err [STAGES];
   logic              w_chain;
   logic              w_hs;
   logic [CNT_W:0]    w_esum;

   approx_add_core #(.WIDTH(WIDTH), .K(K)) u_core (
      .i_a    (in_a),
      .i_b    (in_b),
      .i_mode (mode_t'(in_mode)),
      .o_sum  (w_sum),
      .o_err  (w_err)
   );

   // A stage may load if the output drains or any stage at or after it is empty
   always_comb begin
      w_ld    = '0;
      w_chain = out_ready;
      for (int i = STAGES-1; i >= 0; i--) begin
         w_chain = w_chain | !r_vld[i];
         w_ld[i] = w_chain;
      end
   end

   assign in_ready  = w_ld[0];
   assign out_valid = r_vld[STAGES-1];
   assign out_sum   = r_sum[STAGES-1];
   assign out_err   = r_err[STAGES-1];
   assign w_hs      = out_valid & out_ready;
   assign w_esum    = {1'b0, stat_err_sum} + (CNT_W+1)'(out_err);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < STAGES; i++) begin
            r_sum[i] <= '0;
            r_err[i] <= '0;
         end
      end else begin
         if (w_ld[0]) begin
            r_vld[0] <= in_valid;
            r_sum[0] <= w_sum;
            r_err[0] <= w_err;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (w_ld[i]) begin
               r_vld[i] <= r_vld[i-1];
               r_sum[i] <= r_sum[i-1];
               r_err[i] <= r_err[i-1];
            end
         end
      end
   end

   // Clear takes priority over a coincident handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || stat_clr) begin
         stat_count     <= '0;
         stat_err_count <= '0;
         stat_err_sum   <= '0;
         stat_wce       <= '0;
      end else if (w_hs) begin
         stat_count     <= (&stat_count) ? stat_count : stat_count + CNT_W'(1);
         stat_err_count <= (out_err == '0 || &stat_err_count) ? stat_err_count : stat_err_count + CNT_W'(1);
         stat_err_sum   <= w_esum[CNT_W] ? '1 : w_esum[CNT_W-1:0];
         stat_wce       <= (out_err > stat_wce) ? out_err : stat_wce;
      end
   end
endmodule
